// File: rtl/noc_rx_pkg.sv
// noc_rx_pkg: shared types and constants for the NoC receive PIO bridge.
//   state_t      - bridge FSM states
//   byte_idx_t   - index of the byte within a 32-bit word
//   STAT_*       - bit positions inside pio_status
//   depth_legal  - DEPTH legality check (power of two, 2..8)
package noc_rx_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned LEVEL_FIELD_W = 4;

  localparam int unsigned STAT_TOGGLE    = 0;
  localparam int unsigned STAT_SOF       = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_FULL      = 3;
  localparam int unsigned STAT_LEVEL_LSB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef logic [1:0] byte_idx_t;

  function automatic bit depth_legal(int unsigned depth);
    return (depth >= 2) && (depth <= 8) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/noc_rx_pio_bridge_if.sv
// noc_rx_pio_bridge_if: NoC word valid/ready handshake.
//   noc_data  - 32-bit NoC word
//   noc_valid - noc_data is valid this cycle
//   noc_ready - receiver accepts a word this cycle
// master: NoC side, slave: bridge side.
interface noc_rx_pio_bridge_if;
  import noc_rx_pkg::*;

  logic [WORD_W-1:0] noc_data;
  logic              noc_valid;
  logic              noc_ready;

  modport master (output noc_data, output noc_valid, input noc_ready);
  modport slave  (input noc_data, input noc_valid, output noc_ready);

endinterface

// File: rtl/noc_rx_fifo.sv
// noc_rx_fifo: synchronous word FIFO with wrapping pointers.
//   clk, reset_n     - clock, async active-low reset (clears pointers/level)
//   push, wdata      - write request and word; ignored while full
//   pop, rdata       - read request; rdata shows the head word
//   level            - number of stored words
//   empty, full      - registered status flags
module noc_rx_fifo
  import noc_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WORD_W-1:0]         wdata,
  input  logic                      pop,
  output logic [WORD_W-1:0]         rdata,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  if (!depth_legal(DEPTH)) begin : g_depth_check
    $error("noc_rx_fifo: DEPTH must be a power of two in 2..8");
  end

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_d;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level;
    case ({do_push, do_pop})
      2'b10:   level_d = level + LVL_W'(1);
      2'b01:   level_d = level - LVL_W'(1);
      default: level_d = level;
    endcase
  end

  // Pointers, level and flags; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_d;
      empty <= (level_d == '0);
      full  <= (level_d == LVL_W'(DEPTH));
    end
  end

  // Storage needs no reset; stale entries are never read after pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noc_rx_pio_bridge.sv
// noc_rx_pio_bridge: buffers NoC words and serialises them little-endian
// onto an 8-bit Nios PIO, paced by a software toggle handshake.
//   clk, reset_n  - clock, async active-low reset
//   bus (slave)   - NoC noc_data/noc_valid/noc_ready handshake
//   pio_data      - current byte (Nios input PIO in_port)
//   pio_status    - {level[3:0], full, empty, sof, data_toggle}
//   ack_toggle    - software copies data_toggle here after reading a byte
//   drop_count    - words discarded while full (saturating)
// Build option: define NOC_RX_DROP_CNT_EN to drop words when full instead of
// backpressuring, counting them in drop_count; otherwise drop_count is 0.
module noc_rx_pio_bridge
  import noc_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  noc_rx_pio_bridge_if.slave        bus,
  output logic [BYTE_W-1:0]         pio_data,
  output logic [BYTE_W-1:0]         pio_status,
  input  logic                      ack_toggle,
  output logic [BYTE_W-1:0]         drop_count
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_t            state_q;
  state_t            state_d;
  byte_idx_t         idx_q;
  byte_idx_t         idx_d;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;
  logic [BYTE_W-1:0] pio_data_d;
  logic              toggle_q;
  logic              toggle_d;
  logic              ack_q;
  logic              pending;

  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_empty;
  logic              fifo_full;

  noc_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (bus.noc_data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifdef NOC_RX_DROP_CNT_EN
  // Never backpressure; words arriving while full are discarded and counted.
  assign bus.noc_ready = reset_n;
  assign fifo_push     = bus.noc_valid & reset_n & ~fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (bus.noc_valid && fifo_full && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign bus.noc_ready = reset_n & ~fifo_full;
  assign fifo_push     = bus.noc_valid & bus.noc_ready;
  assign drop_count    = 8'h00;
`endif

  // A byte is outstanding until software mirrors data_toggle on ack_toggle.
  assign pending = toggle_q ^ ack_q;

  // Next-state and datapath decode.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    pio_data_d = pio_data;
    toggle_d   = toggle_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          idx_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        pio_data_d = shift_q[{idx_q, 3'b000} +: BYTE_W];
        toggle_d   = ~toggle_q;
        state_d    = WAIT;
      end
      WAIT: begin
        if (!pending) begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = LOAD;
          end else if (!fifo_empty) begin
            // Chain straight into the next word without passing through IDLE.
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            idx_d    = '0;
            state_d  = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shift_q  <= '0;
      pio_data <= '0;
      toggle_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      pio_data <= pio_data_d;
      toggle_q <= toggle_d;
      ack_q    <= ack_toggle;
    end
  end

  // Status word is a pure concatenation of registered state.
  always_comb begin
    pio_status                                       = '0;
    pio_status[STAT_TOGGLE]                          = toggle_q;
    pio_status[STAT_SOF]                             = (idx_q == 2'd0);
    pio_status[STAT_EMPTY]                           = fifo_empty;
    pio_status[STAT_FULL]                            = fifo_full;
    pio_status[STAT_LEVEL_LSB +: LEVEL_FIELD_W]      = LEVEL_FIELD_W'(fifo_level);
  end

endmodule
